// File: rtl/ext_pkg.sv
// Shared definitions for the extension pipeline: op encodings and lane-count helpers.
package ext_pkg;

   typedef enum logic [2:0] {
      EXT_SEXT = 3'd0,
      EXT_ZEXT = 3'd1,
      EXT_LUI  = 3'd2,
      EXT_BR   = 3'd3,
      EXT_LB   = 3'd4,
      EXT_LBU  = 3'd5,
      EXT_LH   = 3'd6,
      EXT_LHU  = 3'd7
   } ext_op_e;

   localparam int unsigned EXT_DATA_W = 32;
   localparam int unsigned EXT_LANES  = EXT_DATA_W / 8;

   // Byte lanes in a word of the given datapath width.
   function automatic int unsigned ext_lanes(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate / load-lane extender producing data and misalignment error.
module ext_core
   import ext_pkg::*;
#(
   parameter int unsigned IMM_W  = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = $clog2(ext_lanes(DATA_W))
) (
   input  logic [2:0]        op,
   input  logic [IMM_W-1:0]  imm,
   input  logic [DATA_W-1:0] word,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_c,
   output logic              err_c
);

   logic [DATA_W-1:0] sext;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;

   assign sext   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign lane_b = word[{addr, 3'b000} +: 8];
   // Halfword lane ignores addr[0]; a set addr[0] is reported as misaligned instead.
   assign lane_h = word[{addr[ADDR_W-1:1], 4'b0000} +: 16];

   always_comb begin
      data_c = '0;
      err_c  = 1'b0;
      case (ext_op_e'(op))
         EXT_SEXT: data_c = sext;
         EXT_ZEXT: data_c = {{(DATA_W-IMM_W){1'b0}}, imm};
         EXT_LUI:  data_c = {imm, {(DATA_W-IMM_W){1'b0}}};
         EXT_BR:   data_c = sext << 2;
         EXT_LB:   data_c = {{(DATA_W-8){lane_b[7]}}, lane_b};
         EXT_LBU:  data_c = {{(DATA_W-8){1'b0}}, lane_b};
         EXT_LH: begin
            if (addr[0]) err_c  = 1'b1;
            else         data_c = {{(DATA_W-16){lane_h[15]}}, lane_h};
         end
         EXT_LHU: begin
            if (addr[0]) err_c  = 1'b1;
            else         data_c = {{(DATA_W-16){1'b0}}, lane_h};
         end
         default: data_c = '0;
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extension unit: extender on the input side, output register plus skid buffer.
module ext_pipe
   import ext_pkg::*;
#(
   parameter int unsigned IMM_W  = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 5,
   parameter int unsigned ADDR_W = $clog2(ext_lanes(DATA_W))
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_word,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [TAG_W-1:0]  out_tag
);

   logic [DATA_W-1:0] core_data;
   logic              core_err;

   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic              skid_err;
   logic [TAG_W-1:0]  skid_tag;

   logic accept, drain;
   logic out_valid_n, skid_valid_n;
   logic load_out_new, load_out_skid, load_skid;

   ext_core #(
      .IMM_W  (IMM_W),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .op     (in_op),
      .imm    (in_imm),
      .word   (in_word),
      .addr   (in_addr),
      .data_c (core_data),
      .err_c  (core_err)
   );

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   // Next-state: flush wins over accept and drain; SKID refills OUT before new data.
   always_comb begin
      out_valid_n   = out_valid;
      skid_valid_n  = skid_valid;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         out_valid_n  = 1'b0;
         skid_valid_n = 1'b0;
      end else if (!out_valid || drain) begin
         if (skid_valid) begin
            load_out_skid = 1'b1;
            out_valid_n   = 1'b1;
            skid_valid_n  = accept;
            load_skid     = accept;
         end else if (accept) begin
            load_out_new = 1'b1;
            out_valid_n  = 1'b1;
         end else begin
            out_valid_n = 1'b0;
         end
      end else if (accept) begin
         load_skid    = 1'b1;
         skid_valid_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_err    <= 1'b0;
         out_tag    <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_err   <= 1'b0;
         skid_tag   <= '0;
         in_ready   <= 1'b1;
      end else begin
         out_valid  <= out_valid_n;
         skid_valid <= skid_valid_n;
         in_ready   <= !skid_valid_n;
         if (load_out_new) begin
            out_data <= core_data;
            out_err  <= core_err;
            out_tag  <= in_tag;
         end else if (load_out_skid) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            out_tag  <= skid_tag;
         end
         if (load_skid) begin
            skid_data <= core_data;
            skid_err  <= core_err;
            skid_tag  <= in_tag;
         end
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed vector table, stall/flush/reset sequences and a random handshake run for ext_pipe.
module tb_ext_pipe;
   import ext_pkg::*;

   localparam int unsigned IMM_W  = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 5;
   localparam int unsigned ADDR_W = $clog2(EXT_LANES);
   localparam int unsigned NVEC   = 19;

   logic              clk;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [IMM_W-1:0]  in_imm;
   logic [DATA_W-1:0] in_word;
   logic [ADDR_W-1:0] in_addr;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err;
   logic [TAG_W-1:0]  out_tag;

   ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_imm    (in_imm),
      .in_word   (in_word),
      .in_addr   (in_addr),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] imm;
      logic [31:0] word;
      logic [1:0]  addr;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t        vecs [NVEC];
   logic [37:0] q [$];
   int          n_vec;
   int          n_bad;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] imm,
                        input logic [31:0] word, input logic [1:0] addr, input logic [4:0] tag);
      in_valid = v;
      in_op    = op;
      in_imm   = imm;
      in_word  = word;
      in_addr  = addr;
      in_tag   = tag;
   endtask

   // Independent reference: returns {err, data}.
   function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [15:0] imm,
                                           input logic [31:0] word, input logic [1:0] addr);
      logic [7:0]  b;
      logic [15:0] h;
      case (addr)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = addr[1] ? word[31:16] : word[15:0];
      case (op)
         3'd0:    return {1'b0, {16{imm[15]}}, imm};
         3'd1:    return {1'b0, 16'h0000, imm};
         3'd2:    return {1'b0, imm, 16'h0000};
         3'd3:    return {1'b0, {14{imm[15]}}, imm, 2'b00};
         3'd4:    return {1'b0, {24{b[7]}}, b};
         3'd5:    return {1'b0, 24'h0, b};
         3'd6:    return addr[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
         default: return addr[0] ? {1'b1, 32'h0} : {1'b0, 16'h0000, h};
      endcase
   endfunction

   initial begin
      logic [32:0] r;
      n_vec = 0;
      n_bad = 0;

      vecs[0]  = '{3'd0, 16'h8001, 32'h0,        2'd0, 32'hFFFF8001, 1'b0};
      vecs[1]  = '{3'd1, 16'h8001, 32'h0,        2'd0, 32'h00008001, 1'b0};
      vecs[2]  = '{3'd2, 16'h1234, 32'h0,        2'd0, 32'h12340000, 1'b0};
      vecs[3]  = '{3'd3, 16'hFFFF, 32'h0,        2'd0, 32'hFFFFFFFC, 1'b0};
      vecs[4]  = '{3'd4, 16'h0000, 32'h80FF7F01, 2'd3, 32'hFFFFFF80, 1'b0};
      vecs[5]  = '{3'd7, 16'h0000, 32'h80FF7F01, 2'd2, 32'h000080FF, 1'b0};
      vecs[6]  = '{3'd6, 16'h0000, 32'h80FF7F01, 2'd1, 32'h00000000, 1'b1};
      vecs[7]  = '{3'd5, 16'h0000, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0};
      vecs[8]  = '{3'd4, 16'h0000, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0};
      vecs[9]  = '{3'd5, 16'h0000, 32'h80FF7F01, 2'd2, 32'h000000FF, 1'b0};
      vecs[10] = '{3'd6, 16'h0000, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0};
      vecs[11] = '{3'd6, 16'h0000, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0};
      vecs[12] = '{3'd7, 16'hFFFF, 32'h80FF7F01, 2'd3, 32'h00000000, 1'b1};
      vecs[13] = '{3'd0, 16'h7FFF, 32'hFFFFFFFF, 2'd1, 32'h00007FFF, 1'b0};
      vecs[14] = '{3'd3, 16'h4001, 32'h0,        2'd0, 32'h00010004, 1'b0};
      vecs[15] = '{3'd2, 16'hFFFF, 32'h0,        2'd0, 32'hFFFF0000, 1'b0};
      vecs[16] = '{3'd1, 16'hFFFF, 32'hFFFFFFFF, 2'd3, 32'h0000FFFF, 1'b0};
      vecs[17] = '{3'd0, 16'h0000, 32'hFFFFFFFF, 2'd1, 32'h00000000, 1'b0};
      vecs[18] = '{3'd3, 16'h8000, 32'h0,        2'd0, 32'hFFFE0000, 1'b0};

      reset     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0, 5'd0);
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_err",   64'(out_err),   64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      reset = 1'b1;
      @(negedge clk);

      // Back-to-back table, one result per cycle, one cycle after each accept
      for (int i = 0; i < int'(NVEC); i++) begin
         drive(1'b1, vecs[i].op, vecs[i].imm, vecs[i].word, vecs[i].addr, 5'(i));
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(vecs[i].exp_data));
         chk($sformatf("vec%0d_err", i),   64'(out_err),   64'(vecs[i].exp_err));
         chk($sformatf("vec%0d_tag", i),   64'(out_tag),   64'(i));
         chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("table_idle", 64'(out_valid), 64'd0);

      // Stall: three streamed requests with out_ready low
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 16'd1, 32'h0, 2'd0, 5'd1);
      @(negedge clk);
      chk("stall_t1_valid", 64'(out_valid), 64'd1);
      chk("stall_t1_tag",   64'(out_tag),   64'd1);
      chk("stall_t1_ready", 64'(in_ready),  64'd1);
      drive(1'b1, 3'd0, 16'd2, 32'h0, 2'd0, 5'd2);
      @(negedge clk);
      chk("stall_t2_ready", 64'(in_ready), 64'd0);
      chk("stall_t2_tag",   64'(out_tag),  64'd1);
      drive(1'b1, 3'd0, 16'd3, 32'h0, 2'd0, 5'd3);
      @(negedge clk);
      chk("stall_hold_ready", 64'(in_ready), 64'd0);
      chk("stall_hold_tag",   64'(out_tag),  64'd1);
      chk("stall_hold_data",  64'(out_data), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_t2_tag",   64'(out_tag),  64'd2);
      chk("release_t2_data",  64'(out_data), 64'd2);
      chk("release_ready",    64'(in_ready), 64'd1);
      @(negedge clk);
      chk("release_t3_tag",   64'(out_tag),   64'd3);
      chk("release_t3_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("release_idle", 64'(out_valid), 64'd0);

      // Flush with OUT full and a same-cycle accept into SKID
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 16'd4, 32'h0, 2'd0, 5'd4);
      @(negedge clk);
      chk("flush1_pre_tag", 64'(out_tag), 64'd4);
      drive(1'b1, 3'd0, 16'd5, 32'h0, 2'd0, 5'd5);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush1_valid", 64'(out_valid), 64'd0);
      chk("flush1_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      chk("flush1_dropped", 64'(out_valid), 64'd0);

      // Flush with OUT and SKID both full
      drive(1'b1, 3'd0, 16'd6, 32'h0, 2'd0, 5'd6);
      @(negedge clk);
      drive(1'b1, 3'd0, 16'd7, 32'h0, 2'd0, 5'd7);
      @(negedge clk);
      chk("flush2_full_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 3'd0, 16'd9, 32'h0, 2'd0, 5'd9);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("flush2_valid", 64'(out_valid), 64'd0);
      chk("flush2_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      chk("flush2_empty", 64'(out_valid), 64'd0);
      drive(1'b1, 3'd0, 16'd8, 32'h0, 2'd0, 5'd8);
      @(negedge clk);
      chk("flush2_next_valid", 64'(out_valid), 64'd1);
      chk("flush2_next_tag",   64'(out_tag),   64'd8);
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush2_idle", 64'(out_valid), 64'd0);

      // Asynchronous reset during a stall
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 16'd10, 32'h0, 2'd0, 5'd10);
      @(negedge clk);
      drive(1'b1, 3'd0, 16'd11, 32'h0, 2'd0, 5'd11);
      @(negedge clk);
      in_valid = 1'b0;
      chk("areset_pre_ready", 64'(in_ready), 64'd0);
      #2 reset = 1'b0;
      #1;
      chk("areset_valid", 64'(out_valid), 64'd0);
      chk("areset_data",  64'(out_data),  64'd0);
      chk("areset_tag",   64'(out_tag),   64'd0);
      chk("areset_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 3'd0, 16'd12, 32'h0, 2'd0, 5'd12);
      @(negedge clk);
      chk("post_reset_valid", 64'(out_valid), 64'd1);
      chk("post_reset_tag",   64'(out_tag),   64'd12);
      chk("post_reset_data",  64'(out_data),  64'd12);
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", 64'(out_valid), 64'd0);

      // Random handshake against a two-deep reference queue
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("rnd_ready", 64'(in_ready),  64'(q.size() < 2));
         if (out_valid && q.size() != 0)
            chk("rnd_out", 64'({out_tag, out_err, out_data}), 64'(q[0]));
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
               $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
         out_ready = $urandom_range(0, 2) != 0;
         if (out_valid && out_ready && q.size() != 0)
            void'(q.pop_front());
         if (in_valid && in_ready) begin
            r = ref_ext(in_op, in_imm, in_word, in_addr);
            q.push_back({in_tag, r});
         end
         @(negedge clk);
      end
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
